// File: rtl/exec_pkg.sv
// Shared definitions for the start/done execution responder.
//   - opcode encodings carried on the request
//   - FSM state encoding (2 bits; 2'b11 is unused and recovers to IDLE)
//   - default datapath and counter widths
package exec_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_CNT_W = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COMPUTE = 2'b01,
      ST_DONE    = 2'b10
   } state_e;

endpackage

// File: rtl/exec_responder_seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per step, LSB first.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   load_i        capture operands, clear accumulator, arm iteration counter
//   step_i        perform one iteration
//   mcand_i       multiplicand (op_a)
//   mplier_i      multiplier (op_b)
//   finish_o      high during the step that completes the product
//   product_o     accumulator value after the current step; the full product
//                 when finish_o is high
module seq_multiplier
   import exec_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   mcand_i,
   input  logic [WIDTH-1:0]   mplier_i,
   output logic               finish_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int RW = 2 * WIDTH;
   localparam int IW = $clog2(WIDTH + 1);
   localparam logic [IW-1:0] ITER_INIT = IW'(WIDTH);
   localparam logic [IW-1:0] ITER_LAST = IW'(1);

   logic [RW-1:0]    acc_q,    acc_d;
   logic [RW-1:0]    mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [IW-1:0]    iter_q,   iter_d;
   logic [RW-1:0]    acc_next;

   // Remaining-iteration down-counter; the step that sees 1 is the last one.
   assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign product_o = acc_next;
   assign finish_o  = step_i && (iter_q == ITER_LAST);

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      iter_d   = iter_q;
      if (load_i) begin
         acc_d    = '0;
         mcand_d  = RW'(mcand_i);
         mplier_d = mplier_i;
         iter_d   = ITER_INIT;
      end else if (step_i && (iter_q != '0)) begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         iter_d   = iter_q - ITER_LAST;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         iter_q   <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         iter_q   <= iter_d;
      end
   end

endmodule

// File: rtl/exec_responder.sv
// Worker end of the sequencer start/done handshake. Accepts a request
// (opcode + two operands) in IDLE or DONE, executes it, then holds done and
// result until the next request is accepted. Counts completed operations.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         request strobe, honoured only in IDLE or DONE
//   opcode        00 ADD, 01 SUB, 10 MUL, 11 AND
//   op_a, op_b    operands, captured on the accepting edge
//   busy          high in COMPUTE
//   done          high in DONE
//   result        2*WIDTH result of the last completed operation
//   op_count      wrapping count of completed operations
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for the first request after reset
// ST_COMPUTE | executing; 1 cycle for ADD/SUB/AND, WIDTH cycles for MUL
// ST_DONE    | result valid and held; a new start is accepted immediately
module exec_responder
   import exec_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         opcode,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic [CNT_W-1:0]   op_count
);

   localparam int RW = 2 * WIDTH;

   state_e           state_q,  state_d;
   logic [1:0]       opc_q,    opc_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic [RW-1:0]    result_q, result_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic             mul_load;
   logic             mul_step;
   logic             mul_finish;
   logic [RW-1:0]    mul_product;
   logic [RW-1:0]    alu_res;

   seq_multiplier #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (mul_load),
      .step_i    (mul_step),
      .mcand_i   (op_a),
      .mplier_i  (op_b),
      .finish_o  (mul_finish),
      .product_o (mul_product)
   );

   // Operands are zero-extended before SUB so a negative difference comes
   // out as the full-width two's complement value.
   always_comb begin
      alu_res = '0;
      case (opc_q)
         OP_ADD:  alu_res = RW'(a_q) + RW'(b_q);
         OP_SUB:  alu_res = RW'(a_q) - RW'(b_q);
         OP_AND:  alu_res = RW'(a_q & b_q);
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      opc_d    = opc_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      count_d  = count_q;
      mul_load = 1'b0;
      mul_step = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_COMPUTE;
               opc_d    = opcode;
               a_d      = op_a;
               b_d      = op_b;
               mul_load = 1'b1;
            end
         end
         ST_COMPUTE: begin
            if (opc_q == OP_MUL) begin
               mul_step = 1'b1;
               if (mul_finish) begin
                  result_d = mul_product;
                  state_d  = ST_DONE;
                  count_d  = count_q + CNT_W'(1);
               end
            end else begin
               result_d = alu_res;
               state_d  = ST_DONE;
               count_d  = count_q + CNT_W'(1);
            end
         end
         default: begin
            state_d  = ST_IDLE;
            opc_d    = '0;
            a_d      = '0;
            b_d      = '0;
            result_d = '0;
            count_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         opc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         opc_q    <= opc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         count_q  <= count_d;
      end
   end

   assign busy     = (state_q == ST_COMPUTE);
   assign done     = (state_q == ST_DONE);
   assign result   = result_q;
   assign op_count = count_q;

endmodule

// File: tb/tb_exec_responder.sv
module tb_exec_responder;
   import exec_pkg::*;

   localparam int W  = 8;
   localparam int CW = 8;

   logic           clk    = 1'b0;
   logic           rst_n  = 1'b0;
   logic           start  = 1'b0;
   logic [1:0]     opcode = 2'b00;
   logic [W-1:0]   op_a   = '0;
   logic [W-1:0]   op_b   = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] result;
   logic [CW-1:0]  op_count;

   always #5 clk = ~clk;

   exec_responder #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .opcode   (opcode),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .op_count (op_count)
   );

   typedef struct packed {
      logic [2*W-1:0] res;
      logic [CW-1:0]  cnt;
   } exp_t;

   exp_t          exp_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   logic [CW-1:0] cnt_model = '0;
   logic          done_prev = 1'b0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endfunction

   // Scoreboard monitor: every rising edge of done must match the oldest
   // outstanding expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         done_prev = 1'b0;
      end else begin
         if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'(0));
            end else begin
               e = exp_q.pop_front();
               check("result", 32'(result), 32'(e.res));
               check("op_count", 32'(op_count), 32'(e.cnt));
            end
         end
         done_prev = done;
      end
   end

   task automatic push_exp(input logic [2*W-1:0] r);
      exp_t e;
      cnt_model = cnt_model + CW'(1);
      e.res = r;
      e.cnt = cnt_model;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input int budget, output int busy_cycles);
      int guard;
      guard = 0;
      busy_cycles = 0;
      while (done !== 1'b1) begin
         if (busy === 1'b1) busy_cycles++;
         guard++;
         if (guard > budget) begin
            check("done_timeout", 32'(done), 32'(1));
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] opc,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_r, input int exp_lat);
      int lat;
      @(negedge clk);
      start = 1'b1; opcode = opc; op_a = a; op_b = b;
      push_exp(exp_r);
      @(negedge clk);
      start = 1'b0; op_a = ~a; op_b = ~b;
      wait_done(40, lat);
      check({name, "_busy_cycles"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic do_reset();
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      rst_n = 1'b0; start = 1'b0;
      cnt_model = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int lat;
      int done_seen;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_result", 32'(result), 32'(0));
      check("rst_op_count", 32'(op_count), 32'(0));
      rst_n = 1'b1;

      // Reset mid-MUL aborts: no done, no count
      @(negedge clk);
      start = 1'b1; opcode = OP_MUL; op_a = 8'd5; op_b = 8'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_result", 32'(result), 32'(0));
      check("abort_op_count", 32'(op_count), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'(0));

      // Single-cycle ops
      run_op("add_carry", OP_ADD, 8'hFF, 8'h01, 16'h0100, 1);
      run_op("sub_neg", OP_SUB, 8'd3, 8'd5, 16'hFFFE, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("sub_hold_done", 32'(done), 32'(1));
         check("sub_hold_result", 32'(result), 32'h0000FFFE);
      end
      run_op("sub_pos", OP_SUB, 8'd10, 8'd3, 16'h0007, 1);
      run_op("and", OP_AND, 8'hC3, 8'h5A, 16'h0042, 1);

      // Multi-cycle ops, fixed latency
      run_op("mul_5x7", OP_MUL, 8'd5, 8'd7, 16'h0023, 8);
      run_op("mul_zero", OP_MUL, 8'h00, 8'h37, 16'h0000, 8);
      run_op("mul_80x02", OP_MUL, 8'h80, 8'h02, 16'h0100, 8);

      // MUL FFxFF with start pulses while busy
      @(negedge clk);
      start = 1'b1; opcode = OP_MUL; op_a = 8'hFF; op_b = 8'hFF;
      push_exp(16'hFE01);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      for (int k = 0; k < 40 && done !== 1'b1; k++) begin
         if (busy === 1'b1) lat++;
         start  = (k == 2 || k == 4);
         opcode = OP_ADD; op_a = 8'h01; op_b = 8'h01;
         @(negedge clk);
      end
      start = 1'b0;
      check("mul_ff_busy_cycles", 32'(lat), 32'(8));
      repeat (3) @(negedge clk);
      check("mul_ff_done_held", 32'(done), 32'(1));
      check("mul_ff_result_held", 32'(result), 32'h0000FE01);
      check("mul_ff_count", 32'(op_count), 32'(cnt_model));

      // Back-to-back AND with start held high
      do_reset();
      @(negedge clk);
      start = 1'b1; opcode = OP_AND; op_a = 8'hF0; op_b = 8'h3C;
      push_exp(16'h0030);
      @(negedge clk);
      check("b2b_busy1", 32'(busy), 32'(1));
      op_a = 8'h0F; op_b = 8'hFF;
      push_exp(16'h000F);
      @(negedge clk);
      check("b2b_done1", 32'(done), 32'(1));
      @(negedge clk);
      check("b2b_gap1_done", 32'(done), 32'(0));
      check("b2b_gap1_busy", 32'(busy), 32'(1));
      op_a = 8'h00; op_b = 8'hFF;
      push_exp(16'h0000);
      @(negedge clk);
      check("b2b_done2", 32'(done), 32'(1));
      @(negedge clk);
      check("b2b_gap2_done", 32'(done), 32'(0));
      start = 1'b0;
      @(negedge clk);
      check("b2b_done3", 32'(done), 32'(1));
      check("b2b_count", 32'(op_count), 32'(3));
      repeat (2) @(negedge clk);
      check("b2b_done_held", 32'(done), 32'(1));
      check("b2b_count_held", 32'(op_count), 32'(3));

      // Counter wrap
      do_reset();
      for (int i = 0; i < 256; i++) begin
         logic [W-1:0] a, b;
         a = W'(i);
         b = a ^ 8'h5A;
         run_op("wrap_add", OP_ADD, a, b, 16'(a) + 16'(b), 1);
      end
      @(negedge clk);
      check("wrap_count_zero", 32'(op_count), 32'(0));
      check("pending_expected", 32'(exp_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/exec_responder.md
Name: exec_responder

Overview:
- Worker end of the start/done handshake driven by the CPU's main sequencing state machine.
- Accepts a `start` request carrying an opcode and two operands, then executes single-cycle or multi-cycle arithmetic.
- Raises `done` and holds it until the next request is accepted.
- Keeps a wrapping count of completed operations, the mirror of the sequencer's issued-request count.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE or DONE.
- opcode  input  2  00 ADD, 01 SUB, 10 MUL, 11 AND; captured with start.
- op_a  input  WIDTH  operand A, captured with start.
- op_b  input  WIDTH  operand B, captured with start.
- busy  output  1  high while in COMPUTE.
- done  output  1  high in DONE; held until the next accepted start.
- result  output  2*WIDTH  result of the last completed operation; stable while done=1.
- op_count  output  CNT_W  number of completed operations, wrapping.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0, op_count=0.
  - Internal operand, accumulator and iteration registers are cleared.
  - Reset asserted during COMPUTE aborts the operation: no done, no count increment.
- States: IDLE, COMPUTE, DONE. State encoding is 2 bits.
- IDLE:
  - start=1 at edge N: capture opcode/op_a/op_b, go to COMPUTE; busy=1 after edge N.
  - start=0: stay in IDLE.
- COMPUTE, single-cycle ops (ADD/SUB/AND):
  - Result is computed from the captured operands at edge N+1, then state goes to DONE.
  - Request-to-done latency is 1 cycle after the capturing edge.
  - ADD: zero-extended sum; bit WIDTH carries out.
  - SUB: op_a - op_b, two's complement, sign-extended to 2*WIDTH.
  - AND: zero-extended bitwise AND.
- COMPUTE, MUL:
  - Unsigned shift-add, one multiplier bit per cycle, LSB first, using an iteration counter of ceil(log2(WIDTH+1)) bits.
  - After WIDTH iterations the result is written and state goes to DONE.
  - done=1 after edge N+WIDTH.
  - Multiply by 0 still takes WIDTH cycles (fixed latency, no early exit).
- Entering DONE (same edge):
  - result is updated, done=1, busy=0.
  - op_count increments; 2^CNT_W-1 wraps to 0.
- DONE:
  - start=1: capture new operands, go to COMPUTE; done=0 and busy=1 after that edge. Back-to-back requests need no IDLE cycle.
  - start=0: hold done and result indefinitely.
- start while busy=1 is ignored: operands are not recaptured and no queueing occurs.
- start held high continuously: one request is accepted in IDLE; after completion, DONE accepts the next immediately. The block never re-accepts within COMPUTE.
- Operand inputs are don't-care except on an accepting edge.
- Unused/illegal state encoding returns to IDLE with outputs cleared.

Decomposition:
- Shared package exec_pkg holds:
  - opcode constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_AND=2'b11);
  - state constants (ST_IDLE, ST_COMPUTE, ST_DONE);
  - default WIDTH.
- One sub-module, seq_multiplier: a shift-add core with load/step/finish signals, instantiated by exec_responder.
- The ALU for the single-cycle ops stays inline.

Test Plan:
- Reset mid-op: start MUL 5*7, assert rst_n=0 at cycle 3 → busy=0, done=0, result=0, op_count=0 immediately (asynchronously); no done appears afterwards.
- ADD: start with op_a=8'hFF, op_b=8'h01 → done=1 one cycle after capture; result=16'h0100; busy high for exactly 1 cycle; op_count=1.
- SUB underflow: op_a=3, op_b=5 → result=16'hFFFE; done held for 10 idle cycles with result stable.
- MUL: op_a=8'hFF, op_b=8'hFF → busy for exactly 8 cycles, then result=16'hFE01; start pulses during busy are ignored (result unchanged, op_count +1 only).
- Back-to-back: start held high through 3 AND ops (F0&3C, 0F&FF, 00&FF) → results 0030, 000F, 0000; done low exactly one cycle between ops; op_count=3.
- Counter wrap: 256 ADD ops → op_count returns to 0 after the 256th done.
